id_ex_stage: RTL and testbench

//  ID/EX pipeline register that feeds the ALU. Decodes aluop and funct into the 4-bit ALUcontrol.

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU-control decode, operand forwarding and immediate sign-extension,
// all captured on one rising edge with stall (hold), flush (bubble) and asynchronous reset.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic             alusrc,
    input  logic             regdst,
    input  logic             regwrite_in,
    input  logic [RADDR-1:0] rs_addr,
    input  logic [RADDR-1:0] rt_addr,
    input  logic [RADDR-1:0] rd_addr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [15:0]      imm16,
    input  logic             exmem_regwrite,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       ALUcontrol,
    output logic [WIDTH-1:0] store_data,
    output logic [RADDR-1:0] wr_addr,
    output logic             regwrite_out,
    output logic             out_valid,
    output logic             illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;
    logic [WIDTH-1:0] imm_ext;
    logic [3:0]       dec_ctrl;
    logic             dec_illegal;

    // Valid semantics: out_valid marks the EX slot as a real instruction; there is no
    // ready path, stall is the only back-pressure and simply freezes the slot.

    // EX/MEM is the younger result, so it wins over MEM/WB; register 0 is hardwired zero.
    always_comb begin
        fwd_rs = rs_data;
        if (exmem_regwrite && (exmem_rd == rs_addr) && (rs_addr != '0))
            fwd_rs = exmem_result;
        else if (memwb_regwrite && (memwb_rd == rs_addr) && (rs_addr != '0))
            fwd_rs = memwb_result;
    end

    always_comb begin
        fwd_rt = rt_data;
        if (exmem_regwrite && (exmem_rd == rt_addr) && (rt_addr != '0))
            fwd_rt = exmem_result;
        else if (memwb_regwrite && (memwb_rd == rt_addr) && (rt_addr != '0))
            fwd_rt = memwb_result;
    end

    assign imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};

    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b0;
        case (aluop)
            2'b00: dec_ctrl = ALU_ADD;
            2'b01: dec_ctrl = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100100: dec_ctrl = ALU_AND;
                    6'b100101: dec_ctrl = ALU_OR;
                    6'b100000: dec_ctrl = ALU_ADD;
                    6'b100010: dec_ctrl = ALU_SUB;
                    6'b101010: dec_ctrl = ALU_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A flush or an empty decode slot both produce the same bubble as reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A            <= '0;
            B            <= '0;
            ALUcontrol   <= ALU_ADD;
            store_data   <= '0;
            wr_addr      <= '0;
            regwrite_out <= 1'b0;
            out_valid    <= 1'b0;
            illegal      <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            A            <= '0;
            B            <= '0;
            ALUcontrol   <= ALU_ADD;
            store_data   <= '0;
            wr_addr      <= '0;
            regwrite_out <= 1'b0;
            out_valid    <= 1'b0;
            illegal      <= 1'b0;
        end else if (!stall) begin
            A            <= fwd_rs;
            B            <= alusrc ? imm_ext : fwd_rt;
            ALUcontrol   <= dec_illegal ? ALU_ADD : dec_ctrl;
            store_data   <= fwd_rt;
            wr_addr      <= regdst ? rd_addr : rt_addr;
            regwrite_out <= regwrite_in && !dec_illegal;
            out_valid    <= 1'b1;
            illegal      <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode, immediate, forwarding, stall/flush and
// back-to-back capture, each scenario checked inline against hand-computed values.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        alusrc, regdst, regwrite_in;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] A, B, store_data;
    logic [3:0]  ALUcontrol;
    logic [4:0]  wr_addr;
    logic        regwrite_out, out_valid, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // {A, B, store_data, wr_addr, regwrite_out, out_valid, illegal, ALUcontrol}
    logic [107:0] obs;
    assign obs = {A, B, store_data, wr_addr, regwrite_out, out_valid, illegal, ALUcontrol};
    localparam logic [107:0] BUBBLE = {96'h0, 5'd0, 3'b000, 4'b0010};

    id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .aluop(aluop), .funct(funct), .alusrc(alusrc), .regdst(regdst),
        .regwrite_in(regwrite_in), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .A(A), .B(B), .ALUcontrol(ALUcontrol), .store_data(store_data), .wr_addr(wr_addr),
        .regwrite_out(regwrite_out), .out_valid(out_valid), .illegal(illegal)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0; aluop = 2'b00; funct = 6'h00;
        alusrc = 0; regdst = 0; regwrite_in = 0;
        rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0; imm16 = 0;
        exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd);
        in_valid = 1; regwrite_in = 1; regdst = 1; alusrc = 0;
        aluop = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
        rs_data = rsd; rt_data = rtd;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        #2;
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", obs, BUBBLE);
        end
        set_op(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6);
        tick();
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL reset_held: got %h expected %h", obs, BUBBLE);
        end
        #2 rst = 0;
        tick();
        n_checks++;
        if (obs !== {32'h5, 32'h6, 32'h6, 5'd3, 3'b110, 4'b0010}) begin
            n_fail++; $display("FAIL reset_release_capture: got %h", obs);
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs, BUBBLE);
        end
        rst = 0;
        tick();
        n_checks++;
        if (A !== 32'h5 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_recapture: A=%h out_valid=%b expected 5/1", A, out_valid);
        end
    endtask

    task automatic test_decode();
        logic [5:0] fn [5];
        logic [3:0] ex [5];
        fn = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
        ex = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            set_op(2'b10, fn[i], 5'd1, 5'd2, 5'd4, 32'h10, 32'h3);
            tick();
            n_checks++;
            if (ALUcontrol !== ex[i] || illegal !== 1'b0 || regwrite_out !== 1'b1) begin
                n_fail++;
                $display("FAIL decode_funct_%h: ctrl=%b ill=%b rw=%b expected %b/0/1",
                         fn[i], ALUcontrol, illegal, regwrite_out, ex[i]);
            end
        end
        set_op(2'b10, 6'h3F, 5'd1, 5'd2, 5'd4, 32'h10, 32'h3);
        tick();
        n_checks++;
        if ({illegal, regwrite_out, out_valid, ALUcontrol} !== {3'b101, 4'b0010}) begin
            n_fail++; $display("FAIL decode_illegal_funct: ill=%b rw=%b v=%b ctrl=%b expected 1/0/1/0010",
                               illegal, regwrite_out, out_valid, ALUcontrol);
        end
        set_op(2'b11, 6'h20, 5'd1, 5'd2, 5'd4, 32'h10, 32'h3);
        tick();
        n_checks++;
        if ({illegal, regwrite_out, out_valid, ALUcontrol} !== {3'b101, 4'b0010}) begin
            n_fail++; $display("FAIL decode_illegal_aluop: ill=%b rw=%b v=%b ctrl=%b expected 1/0/1/0010",
                               illegal, regwrite_out, out_valid, ALUcontrol);
        end
        set_op(2'b01, 6'h00, 5'd1, 5'd2, 5'd4, 32'h10, 32'h3);
        tick();
        n_checks++;
        if (ALUcontrol !== 4'b0110 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL decode_beq: ctrl=%b ill=%b expected 0110/0", ALUcontrol, illegal);
        end
    endtask

    task automatic test_immediate();
        set_op(2'b00, 6'h00, 5'd1, 5'd2, 5'd4, 32'h10, 32'h1234);
        alusrc = 1; regdst = 0; imm16 = 16'h8001;
        tick();
        n_checks++;
        if (B !== 32'hFFFF8001 || store_data !== 32'h1234 || wr_addr !== 5'd2) begin
            n_fail++; $display("FAIL imm_negative: B=%h sd=%h wr=%0d expected ffff8001/1234/2",
                               B, store_data, wr_addr);
        end
        imm16 = 16'h7FFF;
        tick();
        n_checks++;
        if (B !== 32'h00007FFF) begin
            n_fail++; $display("FAIL imm_positive: B=%h expected 00007fff", B);
        end
    endtask

    task automatic test_forwarding();
        set_op(2'b00, 6'h00, 5'd5, 5'd6, 5'd7, 32'h0000_0055, 32'h0000_0066);
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAAAA0000;
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'h1;
        tick();
        n_checks++;
        if (A !== 32'hAAAA0000) begin
            n_fail++; $display("FAIL fwd_exmem_priority: A=%h expected aaaa0000", A);
        end
        exmem_regwrite = 0;
        tick();
        n_checks++;
        if (A !== 32'h1) begin
            n_fail++; $display("FAIL fwd_memwb: A=%h expected 00000001", A);
        end
        exmem_regwrite = 1; rs_addr = 0; exmem_rd = 0; memwb_rd = 0;
        tick();
        n_checks++;
        if (A !== 32'h55) begin
            n_fail++; $display("FAIL fwd_reg0: A=%h expected 00000055", A);
        end
        rs_addr = 5; exmem_rd = 9; memwb_rd = 6; memwb_result = 32'hBEEF;
        tick();
        n_checks++;
        if (A !== 32'h55 || B !== 32'hBEEF || store_data !== 32'hBEEF) begin
            n_fail++; $display("FAIL fwd_rt: A=%h B=%h sd=%h expected 55/beef/beef", A, B, store_data);
        end
        clear_inputs();
    endtask

    task automatic test_stall_flush();
        logic [107:0] held;
        held = {32'h11, 32'h22, 32'h22, 5'd9, 3'b110, 4'b0010};
        set_op(2'b00, 6'h00, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22);
        tick();
        n_checks++;
        if (obs !== held) begin
            n_fail++; $display("FAIL stall_capture: got %h expected %h", obs, held);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_op(2'b10, 6'h2A, 5'(i + 3), 5'd4, 5'(i + 10), 32'(i * 7 + 1), 32'hF0);
            tick();
            n_checks++;
            if (obs !== held) begin
                n_fail++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, held);
            end
        end
        flush = 1;
        tick();
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL stall_flush: got %h expected %h", obs, BUBBLE);
        end
        flush = 0; stall = 0;
        set_op(2'b00, 6'h00, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22);
        tick();
        n_checks++;
        if (obs !== held) begin
            n_fail++; $display("FAIL stall_resume: got %h expected %h", obs, held);
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL invalid_bubble: got %h expected %h", obs, BUBBLE);
        end
        set_op(2'b00, 6'h00, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22);
        tick();
        stall = 1;
        #2 rst = 1;
        #1;
        n_checks++;
        if (obs !== BUBBLE) begin
            n_fail++; $display("FAIL reset_mid_stall: got %h expected %h", obs, BUBBLE);
        end
        rst = 0; stall = 0;
    endtask

    task automatic test_back_to_back();
        // Scoreboard: {A, wr_addr, ALUcontrol}
        logic [40:0] exp_q[$];
        logic [40:0] exp_v;
        logic [5:0]  fn [4];
        logic [3:0]  ex [4];
        fn = '{6'h24, 6'h25, 6'h22, 6'h2A};
        ex = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
        for (int i = 0; i < 4; i++) begin
            set_op(2'b10, fn[i], 5'd1, 5'd2, 5'(i + 20), 32'(32'h100 + i), 32'h3);
            exp_q.push_back({32'(32'h100 + i), 5'(i + 20), ex[i]});
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({A, wr_addr, ALUcontrol} !== exp_v || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b_op_%0d: got %h v=%b expected %h v=1",
                                   i, {A, wr_addr, ALUcontrol}, out_valid, exp_v);
            end
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || regwrite_out !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: v=%b rw=%b expected 0/0", out_valid, regwrite_out);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_immediate();
        test_forwarding();
        test_stall_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
